// File: rtl/lsu_pkg.sv
// Shared load/store definitions: memop codes, sequencer states and the
// request legality rule used by the LSU and the future fetch-side checker.
package lsu_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD_RD  = 3'd1;
    localparam logic [2:0] S_LD_CAP = 3'd2;
    localparam logic [2:0] S_ST_RD  = 3'd3;
    localparam logic [2:0] S_ST_WR  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    typedef struct packed {
        logic       we;
        logic [2:0] op;
        logic [4:0] rd;
    } lsu_ctl_t;

    // Unsigned memops only make sense for loads.
    function automatic logic lsu_illegal(
        input logic       we,
        input logic [2:0] op,
        input logic [1:0] lo
    );
        logic bad;
        case (op)
            MOP_B:   bad = 1'b0;
            MOP_H:   bad = lo[0];
            MOP_W:   bad = |lo;
            MOP_BU:  bad = we;
            MOP_HU:  bad = we | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational memop legality check (alignment, opcode, store signedness).
module lsu_align_chk
    import lsu_pkg::*;
(
    input  logic       we,
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       illegal
);

    assign illegal = lsu_illegal(we, op, addr_lo);

endmodule

// File: rtl/lsu_dmem_seq.sv
// Load/store sequencer between execute and dmem: read edge, merge read,
// write edge. Optional counters under `LSU_DMEM_STATS_EN.
module lsu_dmem_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemdatain,
    output logic [2:0]        dmemop,
    output logic              dmemwe,
    output logic              dmemrden,
    output logic              dmemwren,
    input  logic [DATA_W-1:0] dmemdataout
`ifdef LSU_DMEM_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
`endif
);

    // dmem only decodes the byte offset plus MEM_AW word bits.
    localparam logic [ADDR_W-1:0] AMASK =
        ADDR_W'((64'd1 << (MEM_AW + 2)) - 64'd1);

    logic [2:0]        state_q, state_d;
    lsu_ctl_t          ctl_q, ctl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              illegal;

    lsu_align_chk u_chk (
        .we      (req_we),
        .op      (req_op),
        .addr_lo (req_addr[1:0]),
        .illegal (illegal)
    );

    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ctl_d   = '{we: req_we, op: req_op, rd: req_rd};
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = illegal;
                    if (illegal)     state_d = S_RESP;
                    else if (req_we) state_d = S_ST_RD;
                    else             state_d = S_LD_RD;
                end
            end
            S_LD_RD:  state_d = S_LD_CAP;
            S_LD_CAP: begin
                rdata_d = dmemdataout;
                state_d = S_RESP;
            end
            S_ST_RD:  state_d = S_ST_WR;
            S_ST_WR:  state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ctl_q   <= '{we: 1'b0, op: MOP_W, rd: 5'd0};
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = ctl_q.rd;
    assign resp_err   = err_q;

    assign dmemaddr   = addr_q & AMASK;
    assign dmemdatain = wdata_q;
    assign dmemop     = ctl_q.op;
    assign dmemwe     = (state_q == S_ST_RD) | (state_q == S_ST_WR);
    assign dmemrden   = (state_q == S_LD_RD) | (state_q == S_ST_RD);
    assign dmemwren   = (state_q == S_ST_WR);

`ifdef LSU_DMEM_STATS_EN
    logic [31:0] ld_cnt_q, ld_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;
    logic [31:0] er_cnt_q, er_cnt_d;
    logic        hs;

    assign hs = resp_valid & resp_ready;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        er_cnt_d = er_cnt_q;
        if (hs) begin
            if (err_q)         er_cnt_d = er_cnt_q + 32'd1;
            else if (ctl_q.we) st_cnt_d = st_cnt_q + 32'd1;
            else               ld_cnt_d = ld_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign stat_loads  = ld_cnt_q;
    assign stat_stores = st_cnt_q;
    assign stat_errs   = er_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_dmem_seq.sv
// Scoreboard bench for lsu_dmem_seq with a word-level dmem model and a
// byte-level reference memory.
module tb_lsu_dmem_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic [4:0]  req_rd = 5'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdatain;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic        dmemrden;
    logic        dmemwren;
    logic [31:0] dmemdataout = 32'b0;
`ifdef LSU_DMEM_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    always #5 clk = ~clk;

    lsu_dmem_seq dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err),
        .dmemaddr    (dmemaddr),
        .dmemdatain  (dmemdatain),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dmemrden    (dmemrden),
        .dmemwren    (dmemwren),
        .dmemdataout (dmemdataout)
`ifdef LSU_DMEM_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- dmem model (word array) ----------------
    logic [31:0] dmem [64];

    function automatic logic [31:0] dm_ext(input logic [31:0] w,
                                           input logic [2:0] op,
                                           input logic [1:0] lo);
        logic [31:0] s;
        s = w >> (8 * lo);
        case (op)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] dm_merge(input logic [31:0] w,
                                             input logic [31:0] d,
                                             input logic [2:0] op,
                                             input logic [1:0] lo);
        logic [31:0] m;
        case (op[1:0])
            2'b00:   m = 32'h000000FF << (8 * lo);
            2'b01:   m = 32'h0000FFFF << (8 * lo);
            default: m = 32'hFFFFFFFF;
        endcase
        return (w & ~m) | ((d << (8 * lo)) & m);
    endfunction

    always @(posedge clk) begin
        if (dmemrden)
            dmemdataout <= dm_ext(dmem[dmemaddr[7:2]], dmemop, dmemaddr[1:0]);
        if (dmemwren && dmemwe)
            dmem[dmemaddr[7:2]] <= dm_merge(dmem[dmemaddr[7:2]], dmemdatain,
                                            dmemop, dmemaddr[1:0]);
    end

    // ---------------- reference model (byte array) ----------------
    logic [7:0] ref_mem [256];

    function automatic int op_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_illegal(input logic we, input logic [2:0] op,
                                       input logic [31:0] a);
        if (op == 3'd3 || op > 3'd5) return 1'b1;
        if (we && op >= 3'd4) return 1'b1;
        return (int'(a[1:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op,
                                             input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = op_size(op);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(int'(a[7:0]) + i) % 256]) << (8 * i));
        if (op < 3'd4 && n < 4 && v[8 * n - 1])
            v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] d);
        for (int i = 0; i < op_size(op); i++)
            ref_mem[(int'(a[7:0]) + i) % 256] = 8'(d >> (8 * i));
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cls;
    } exp_t;

    exp_t sbq[$];
    int cnt_ld = 0;
    int cnt_st = 0;
    int cnt_er = 0;

    logic [31:0] cur_addr = 32'd0;
    logic [31:0] cur_wd = 32'd0;
    logic [2:0]  cur_op = 3'd0;
    int rden_cnt = 0;
    int wren_cnt = 0;
    int rr_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = 1'($urandom_range(0, 1));
                1:       resp_ready = 1'b0;
                default: resp_ready = 1'b1;
            endcase
        end
    end

    // Response monitor: pops on each handshake, checks hold stability.
    initial begin
        logic        pv;
        logic [31:0] pr;
        logic [4:0]  prd;
        logic        pe;
        exp_t        e;
        pv = 1'b0;
        pr = 32'd0;
        prd = 5'd0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                continue;
            end
            if (pv) begin
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_rdata", resp_rdata, pr);
                check("hold_rd", 32'(resp_rd), 32'(prd));
                check("hold_err", 32'(resp_err), 32'(pe));
                check("hold_req_ready", 32'(req_ready), 32'd0);
            end
            if (resp_valid && resp_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got response rd %0d with empty queue", resp_rd);
                end else begin
                    e = sbq.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_rd", 32'(resp_rd), 32'(e.rd));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    if (e.cls == 0) cnt_ld++;
                    else if (e.cls == 1) cnt_st++;
                    else cnt_er++;
                end
            end
            pv = resp_valid && !resp_ready;
            pr = resp_rdata;
            prd = resp_rd;
            pe = resp_err;
        end
    end

    // dmem port monitor: strobe counts and address/op/data stability.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (dmemrden) rden_cnt++;
                if (dmemwren) wren_cnt++;
                if (dmemrden || dmemwren) begin
                    check("dmem_addr", dmemaddr, cur_addr & 32'h0001FFFF);
                    check("dmem_op", 32'(dmemop), 32'(cur_op));
                    if (dmemwe) check("dmem_wdata", dmemdatain, cur_wd);
                end
                if (dmemwren) check("dmem_we_on_wr", 32'(dmemwe), 32'd1);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd);
        cur_addr = addr;
        cur_op = op;
        cur_wd = wd;
        rden_cnt = 0;
        wren_cnt = 0;
        req_we = we;
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        req_rd = rd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd);
        exp_t e;
        int   k;
        bit   ill;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: req_ready %0d after 50 cycles", req_ready);
            return;
        end
        ill = ref_illegal(we, op, addr);
        e.rd = rd;
        e.err = ill;
        e.cls = ill ? 2 : (we ? 1 : 0);
        e.rdata = (ill || we) ? 32'd0 : ref_load(op, addr);
        if (!ill && we) ref_store(op, addr, wd);
        sbq.push_back(e);
        drive_req(we, op, addr, wd, rd);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 20);
        check("latency", 32'(k), ill ? 32'd1 : 32'd3);
        k = 0;
        while (sbq.size() != 0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        check("resp_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
        check("rden_count", 32'(rden_cnt), ill ? 32'd0 : 32'd1);
        check("wren_count", 32'(wren_cnt), (ill || !we) ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  op;
        logic        we;
        int          k;
        for (int w = 0; w < 64; w++) begin
            r = (w == 4) ? 32'hDEADBEEF : $urandom;
            dmem[w] <= r;
            for (int b = 0; b < 4; b++) ref_mem[w * 4 + b] = 8'(r >> (8 * b));
        end

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_dmemwe", 32'(dmemwe), 32'd0);
        check("rst_dmemrden", 32'(dmemrden), 32'd0);
        check("rst_dmemwren", 32'(dmemwren), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dmemaddr", dmemaddr, 32'd0);
        check("rst_dmemdatain", dmemdatain, 32'd0);
        check("rst_dmemop", 32'(dmemop), 32'd2);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed: lw, preload word, sb merge, readback, misaligned lh
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 5'd2);
        do_req(1'b1, 3'b000, 32'h13, 32'h000000AB, 5'd3);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd4);
        check("sb_merge_mem", dmem[4], 32'hAB223344);
        do_req(1'b0, 3'b001, 32'h21, 32'h0, 5'd5);

        // Back-pressure: hold resp_ready low for 5 response cycles
        rr_mode = 1;
        fork
            do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd6);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!resp_valid && k < 20);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid", 32'(resp_valid), 32'd1);
                    check("bp_req_ready", 32'(req_ready), 32'd0);
                end
                rr_mode = 2;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!(resp_valid && resp_ready) && k < 20);
                @(negedge clk);
                check("bp_valid_drop", 32'(resp_valid), 32'd0);
                check("bp_accept_again", 32'(req_ready), 32'd1);
            end
        join
        rr_mode = 0;

        // Reset during ST_RD abandons the store
        do_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd7);
        @(negedge clk);
        drive_req(1'b1, 3'b010, 32'h40, 32'h12345678, 5'd8);
        @(negedge clk);
        check("strd_rden", 32'(dmemrden), 32'd1);
        check("strd_we", 32'(dmemwe), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(dmemwe), 32'd0);
        check("mid_rst_rden", 32'(dmemrden), 32'd0);
        check("mid_rst_wren", 32'(dmemwren), 32'd0);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        cnt_ld = 0;
        cnt_st = 0;
        cnt_er = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_write", 32'(wren_cnt), 32'd0);
        check("mid_rst_idle", 32'(req_ready), 32'd1);
        check("mid_rst_mem", dmem[16], 32'hCAFEF00D);

        // Post-reset mix: 2 loads, 1 store, 1 illegal
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd9);
        do_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 5'd10);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 5'd11);
        do_req(1'b1, 3'b100, 32'h30, 32'h0, 5'd12);
`ifdef LSU_DMEM_STATS_EN
        repeat (2) @(negedge clk);
        check("stat_loads_dir", stat_loads, 32'd2);
        check("stat_stores_dir", stat_stores, 32'd1);
        check("stat_errs_dir", stat_errs, 32'd1);
`endif

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
            do_req(we, op, a, $urandom, 5'($urandom));
        end

        repeat (3) @(negedge clk);
`ifdef LSU_DMEM_STATS_EN
        check("stat_loads", stat_loads, 32'(cnt_ld));
        check("stat_stores", stat_stores, 32'(cnt_st));
        check("stat_errs", stat_errs, 32'(cnt_er));
`endif
        for (int w = 0; w < 64; w++) begin
            r = {ref_mem[w * 4 + 3], ref_mem[w * 4 + 2],
                 ref_mem[w * 4 + 1], ref_mem[w * 4]};
            check("final_mem", dmem[w], r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
